// File: rtl/gpu_write_arbiter.sv
// Two-requester round-robin arbiter feeding the graphics-processor instruction FIFO.
// Each accepted word pair is written in a single-cycle strobe, followed by a one-cycle gap.
module gpu_write_arbiter #(
    parameter bit SYNC_REQ1      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data_a,
    input  logic [31:0] req0_data_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data_a,
    input  logic [31:0] req1_data_b,
    output logic        req1_ready,
    input  logic        screen_export,
    input  logic        wrfull,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic        wrreg,
    output logic [1:0]  grant,
    output logic [15:0] write_count,
    output logic        timeout
);

    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               elig0;
    logic               elig1;
    logic               pick1;
    logic               grant_ok;
    logic               stall;
    logic               last_req1;
    logic [15:0]        count_next;
    logic [STALL_W-1:0] stall_count;
    logic [STALL_W-1:0] stall_next;

    // Arbitration, ready generation and next-state logic; ready is gated by reset
    // so a requester can never see an acknowledge while the block is held in reset.
    always_comb begin
        elig0      = req0_valid;
        elig1      = req1_valid && (screen_export || !SYNC_REQ1);
        pick1      = elig1 && (!elig0 || !last_req1);
        grant_ok   = (state == IDLE) && !wrfull && (elig0 || elig1) && reset_reset_n;
        req0_ready = grant_ok && !pick1;
        req1_ready = grant_ok && pick1;
        stall      = (state == IDLE) && wrfull && (elig0 || elig1);
        wrreg      = (state == WRITE);
        state_next = state;
        count_next = write_count;
        stall_next = '0;

        case (state)
            IDLE: begin
                if (grant_ok) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = GAP;
                count_next = write_count + 16'd1;
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Saturate at the limit so a very long stall cannot wrap the counter.
        if (stall) begin
            stall_next = (stall_count == STALL_LIMIT) ? stall_count : stall_count + 1'b1;
        end
    end

    // State, output data and bookkeeping registers; the last-grant pointer resets to
    // requester 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state       <= IDLE;
            data_a      <= '0;
            data_b      <= '0;
            grant       <= 2'b00;
            write_count <= '0;
            timeout     <= 1'b0;
            stall_count <= '0;
            last_req1   <= 1'b1;
        end else begin
            state       <= state_next;
            write_count <= count_next;
            stall_count <= stall_next;
            if (stall_next == STALL_LIMIT) begin
                timeout <= 1'b1;
            end
            if (grant_ok) begin
                data_a    <= pick1 ? req1_data_a : req0_data_a;
                data_b    <= pick1 ? req1_data_b : req0_data_b;
                grant     <= pick1 ? 2'b10 : 2'b01;
                last_req1 <= pick1;
            end
        end
    end

endmodule
